// File: rtl/tmr_mon_pkg.sv
// Shared types and helpers for the TMR fault monitor.
//   replica_state_e        : per-replica health state
//   DEFAULT_PERSIST_THRESH : default consecutive-mismatch count declaring FAILED
//   sat_add / sat_inc      : saturating arithmetic on up to 32-bit counters
package tmr_mon_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_SUSPECT = 2'b01,
    ST_FAILED  = 2'b10
  } replica_state_e;

  localparam int unsigned DEFAULT_PERSIST_THRESH = 4;

  // a + b clamped to max_v; the sum is formed one bit wider so it cannot wrap
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max_v}) ? max_v : s[31:0];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] a,
                                          input logic [31:0] max_v);
    return sat_add(a, 32'd1, max_v);
  endfunction

endpackage

// File: rtl/tmr_fault_monitor_if.sv
// Failure-event handshake between the monitor and the system controller.
//   evt_valid : failure event pending (monitor -> controller)
//   evt_id    : replica index 1..3 of the presented event
//   evt_ack   : controller accepts the presented event
interface tmr_fault_monitor_if;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ack;

  modport master (output evt_valid, output evt_id, input evt_ack);
  modport slave  (input evt_valid, input evt_id, output evt_ack);
endinterface

// File: rtl/tmr_replica_tracker.sv
// Health tracker for one replica: OK/SUSPECT/FAILED FSM, consecutive-mismatch
// run counter and saturating mismatch count.
//   clk, rst       : clock, async active-high reset
//   clear          : synchronous clear, wins over everything else
//   sample_en      : evaluate mismatch this cycle; otherwise hold
//   mismatch       : replica differs from the voted value
//   state, err_cnt : registered health state and mismatch count
//   fail_entry_c   : this edge moves the replica into FAILED (comb)
//   episode_end_c  : this edge ends a transient episode (comb)
module tmr_replica_tracker
  import tmr_mon_pkg::*;
#(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned PERSIST_THRESH = DEFAULT_PERSIST_THRESH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_en,
  input  logic             mismatch,
  output replica_state_e   state,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_entry_c,
  output logic             episode_end_c
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [3:0]       RUN_THRESH = 4'(PERSIST_THRESH);

  replica_state_e   state_n;
  logic [3:0]       run_q;
  logic [3:0]       run_n;
  logic [CNT_W-1:0] err_n;

  // State, run and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_OK;
      run_q   <= '0;
      err_cnt <= '0;
    end else if (clear) begin
      state   <= ST_OK;
      run_q   <= '0;
      err_cnt <= '0;
    end else begin
      state   <= state_n;
      run_q   <= run_n;
      err_cnt <= err_n;
    end
  end

  // Next-state, run and count; unsampled cycles leave everything untouched
  always_comb begin
    state_n       = state;
    run_n         = run_q;
    err_n         = err_cnt;
    fail_entry_c  = 1'b0;
    episode_end_c = 1'b0;
    if (sample_en) begin
      if (mismatch) begin
        err_n = CNT_W'(sat_inc(32'(err_cnt), 32'(CNT_MAX)));
      end
      case (state)
        ST_OK: begin
          if (mismatch) begin
            state_n = ST_SUSPECT;
            run_n   = 4'd1;
          end
        end
        ST_SUSPECT: begin
          if (mismatch) begin
            run_n = 4'(run_q + 4'd1);
            if (run_n == RUN_THRESH) begin
              state_n      = ST_FAILED;
              fail_entry_c = 1'b1;
            end
          end else begin
            state_n       = ST_OK;
            run_n         = '0;
            episode_end_c = 1'b1;
          end
        end
        ST_FAILED: begin
          state_n = ST_FAILED;
        end
        default: begin
          state_n = ST_OK;
          run_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tmr_fault_monitor.sv
// Fault observer for the triple-redundant counter: classifies replica
// disagreement as transient or persistent, counts mismatches and reports
// failed replicas over a valid/ack event interface.
// Optional feature macro: TMR_MON_NOMAJ_DETECT_EN builds the sticky
// no-majority detector behind uncorr; without it uncorr is tied low.
//   clk, rst            : clock, async active-high reset
//   sample_en           : sample replicas this cycle
//   q_1..q_3, voted_q   : replica outputs and voter output
//   clear               : synchronous clear of all monitor state
//   state_1..state_3    : replica state 00 OK, 01 SUSPECT, 10 FAILED
//   err_cnt_1..err_cnt_3: saturating mismatch counts
//   trans_cnt           : saturating count of transient episodes
//   evt                 : failure event handshake (valid/id comb from pending)
//   uncorr              : sticky no-majority flag
module tmr_fault_monitor
  import tmr_mon_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned PERSIST_THRESH = DEFAULT_PERSIST_THRESH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic [WIDTH-1:0]         q_1,
  input  logic [WIDTH-1:0]         q_2,
  input  logic [WIDTH-1:0]         q_3,
  input  logic [WIDTH-1:0]         voted_q,
  input  logic                     clear,
  output logic [1:0]               state_1,
  output logic [1:0]               state_2,
  output logic [1:0]               state_3,
  output logic [CNT_W-1:0]         err_cnt_1,
  output logic [CNT_W-1:0]         err_cnt_2,
  output logic [CNT_W-1:0]         err_cnt_3,
  output logic [CNT_W-1:0]         trans_cnt,
  tmr_fault_monitor_if.master      evt,
  output logic                     uncorr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  replica_state_e st_1, st_2, st_3;
  logic [2:0]     fail_entry;
  logic [2:0]     episode_end;
  logic [2:0]     pending;
  logic [2:0]     ack_mask;
  logic [1:0]     n_end;

  tmr_replica_tracker #(.CNT_W(CNT_W), .PERSIST_THRESH(PERSIST_THRESH)) u_trk_1 (
    .clk(clk), .rst(rst), .clear(clear), .sample_en(sample_en),
    .mismatch(q_1 != voted_q), .state(st_1), .err_cnt(err_cnt_1),
    .fail_entry_c(fail_entry[0]), .episode_end_c(episode_end[0])
  );

  tmr_replica_tracker #(.CNT_W(CNT_W), .PERSIST_THRESH(PERSIST_THRESH)) u_trk_2 (
    .clk(clk), .rst(rst), .clear(clear), .sample_en(sample_en),
    .mismatch(q_2 != voted_q), .state(st_2), .err_cnt(err_cnt_2),
    .fail_entry_c(fail_entry[1]), .episode_end_c(episode_end[1])
  );

  tmr_replica_tracker #(.CNT_W(CNT_W), .PERSIST_THRESH(PERSIST_THRESH)) u_trk_3 (
    .clk(clk), .rst(rst), .clear(clear), .sample_en(sample_en),
    .mismatch(q_3 != voted_q), .state(st_3), .err_cnt(err_cnt_3),
    .fail_entry_c(fail_entry[2]), .episode_end_c(episode_end[2])
  );

  assign state_1 = st_1;
  assign state_2 = st_2;
  assign state_3 = st_3;

  // Number of replicas ending a transient episode on this edge
  assign n_end = 2'(episode_end[0]) + 2'(episode_end[1]) + 2'(episode_end[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trans_cnt <= '0;
    end else if (clear) begin
      trans_cnt <= '0;
    end else if (n_end != 2'd0) begin
      trans_cnt <= CNT_W'(sat_add(32'(trans_cnt), 32'(n_end), 32'(CNT_MAX)));
    end
  end

  // Event presentation: lowest pending index; ack retires exactly that bit
  always_comb begin
    evt.evt_valid = |pending;
    evt.evt_id    = 2'd0;
    if (pending[0])      evt.evt_id = 2'd1;
    else if (pending[1]) evt.evt_id = 2'd2;
    else if (pending[2]) evt.evt_id = 2'd3;
    ack_mask = 3'b000;
    if (evt.evt_ack) begin
      ack_mask = pending & 3'(~pending + 3'd1);
    end
  end

  // A replica enters FAILED once per clear/reset, so set and ack never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (clear) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~ack_mask) | fail_entry;
    end
  end

`ifdef TMR_MON_NOMAJ_DETECT_EN
  // Sticky flag: all three replicas pairwise different on a sampled cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uncorr <= 1'b0;
    end else if (clear) begin
      uncorr <= 1'b0;
    end else if (sample_en && (q_1 != q_2) && (q_2 != q_3) && (q_1 != q_3)) begin
      uncorr <= 1'b1;
    end
  end
`else
  assign uncorr = 1'b0;
`endif

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Self-checking bench for tmr_fault_monitor: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model of replica health, counters and the event mask.
module tb_tmr_fault_monitor;

  localparam int TH   = 4;
  localparam int CMAX = 255;
`ifdef TMR_MON_NOMAJ_DETECT_EN
  localparam bit NOMAJ = 1'b1;
`else
  localparam bit NOMAJ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en = 1'b0;
  logic [7:0] q_1 = 8'h10, q_2 = 8'h10, q_3 = 8'h10, voted_q = 8'h10;
  logic       clear = 1'b0;
  logic [1:0] state_1, state_2, state_3;
  logic [7:0] err_cnt_1, err_cnt_2, err_cnt_3, trans_cnt;
  logic       uncorr;

  tmr_fault_monitor_if evt ();

  tmr_fault_monitor #(.WIDTH(8), .CNT_W(8), .PERSIST_THRESH(TH)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en),
    .q_1(q_1), .q_2(q_2), .q_3(q_3), .voted_q(voted_q), .clear(clear),
    .state_1(state_1), .state_2(state_2), .state_3(state_3),
    .err_cnt_1(err_cnt_1), .err_cnt_2(err_cnt_2), .err_cnt_3(err_cnt_3),
    .trans_cnt(trans_cnt), .evt(evt), .uncorr(uncorr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_err[1:3]    = '{0, 0, 0};
  int m_run[1:3]    = '{0, 0, 0};
  bit m_failed[1:3] = '{0, 0, 0};
  bit m_pend[1:3]   = '{0, 0, 0};
  int m_trans       = 0;
  bit m_unc         = 1'b0;
  int m_ends;
  int m_lo;

  function automatic int lowest_pending();
    for (int i = 1; i <= 3; i++) if (m_pend[i]) return i;
    return 0;
  endfunction

  function automatic int exp_state(input int i);
    if (m_failed[i]) return 2;
    if (m_run[i] > 0) return 1;
    return 0;
  endfunction

  function automatic bit q_differs(input int i);
    case (i)
      1: return q_1 != voted_q;
      2: return q_2 != voted_q;
      default: return q_3 != voted_q;
    endcase
  endfunction

  task automatic model_zero();
    for (int i = 1; i <= 3; i++) begin
      m_err[i] = 0; m_run[i] = 0; m_failed[i] = 0; m_pend[i] = 0;
    end
    m_trans = 0;
    m_unc   = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_zero();
    end else if (clear) begin
      model_zero();
    end else begin
      m_lo = lowest_pending();
      if (evt.evt_ack && m_lo != 0) m_pend[m_lo] = 1'b0;
      m_ends = 0;
      if (sample_en) begin
        for (int i = 1; i <= 3; i++) begin
          if (q_differs(i)) begin
            if (m_err[i] < CMAX) m_err[i]++;
            if (!m_failed[i]) begin
              m_run[i]++;
              if (m_run[i] == TH) begin
                m_failed[i] = 1'b1;
                m_pend[i]   = 1'b1;
              end
            end
          end else if (!m_failed[i] && m_run[i] > 0) begin
            m_run[i] = 0;
            m_ends++;
          end
        end
        if (q_1 != q_2 && q_2 != q_3 && q_1 != q_3) m_unc = NOMAJ;
      end
      m_trans = (m_trans + m_ends > CMAX) ? CMAX : m_trans + m_ends;
    end
  end

  // Every-cycle comparison, on the inactive edge
  always @(negedge clk) begin
    chk("state_1", state_1, exp_state(1));
    chk("state_2", state_2, exp_state(2));
    chk("state_3", state_3, exp_state(3));
    chk("err_cnt_1", err_cnt_1, m_err[1]);
    chk("err_cnt_2", err_cnt_2, m_err[2]);
    chk("err_cnt_3", err_cnt_3, m_err[3]);
    chk("trans_cnt", trans_cnt, m_trans);
    chk("evt_valid", evt.evt_valid, (lowest_pending() != 0) ? 1 : 0);
    chk("evt_id", evt.evt_id, lowest_pending());
    chk("uncorr", uncorr, m_unc);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit sen, input logic [7:0] a, b, c, v,
                     input bit clr, input bit ack);
    @(negedge clk); #1;
    sample_en = sen; q_1 = a; q_2 = b; q_3 = c; voted_q = v;
    clear = clr; evt.evt_ack = ack;
    @(posedge clk); #1;
  endtask

  localparam logic [7:0] V = 8'h10;
  localparam logic [7:0] B = 8'h11;

  bit         bad[1:3];
  logic [7:0] rq[1:3];
  logic [7:0] rv;

  initial begin
    rst = 1'b1;
    evt.evt_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst state_1", state_1, 0);
    chk("rst err_cnt_1", err_cnt_1, 0);
    chk("rst trans_cnt", trans_cnt, 0);
    chk("rst evt_valid", evt.evt_valid, 0);
    chk("rst evt_id", evt.evt_id, 0);
    chk("rst uncorr", uncorr, 0);
    @(negedge clk); #1;
    rst = 1'b0;

    // transient on replica 2
    cyc(1, V, B, V, V, 0, 0); chk("trans s2 a", state_2, 1);
    cyc(1, V, B, V, V, 0, 0); chk("trans s2 b", state_2, 1);
    cyc(1, V, V, V, V, 0, 0); chk("trans s2 c", state_2, 0);
    chk("trans err2", err_cnt_2, 2);
    chk("trans cnt", trans_cnt, 1);
    chk("trans no evt", evt.evt_valid, 0);

    // persistent on replica 3
    repeat (3) cyc(1, V, V, B, V, 0, 0);
    chk("pers s3 suspect", state_3, 1);
    chk("pers no evt yet", evt.evt_valid, 0);
    cyc(1, V, V, B, V, 0, 0);
    chk("pers s3 failed", state_3, 2);
    chk("pers evt_valid", evt.evt_valid, 1);
    chk("pers evt_id", evt.evt_id, 3);
    cyc(1, V, V, V, V, 0, 0);
    chk("pers evt held", evt.evt_id, 3);
    cyc(1, V, V, V, V, 0, 1);
    chk("pers acked", evt.evt_valid, 0);
    chk("pers s3 sticky", state_3, 2);
    chk("pers err3", err_cnt_3, 4);
    cyc(1, V, V, V, V, 1, 0);
    chk("clear s3", state_3, 0);
    chk("clear trans", trans_cnt, 0);

    // simultaneous failures of 1 and 2
    repeat (4) cyc(1, B, B, V, V, 0, 0);
    chk("simul id1", evt.evt_id, 1);
    chk("simul s2", state_2, 2);
    cyc(1, V, V, V, V, 0, 1);
    chk("simul id2", evt.evt_id, 2);
    chk("simul valid2", evt.evt_valid, 1);
    cyc(1, V, V, V, V, 0, 1);
    chk("simul drained", evt.evt_valid, 0);
    cyc(1, V, V, V, V, 1, 0);

    // sampling gap does not break the run
    repeat (2) cyc(1, B, V, V, V, 0, 0);
    cyc(0, V, V, V, V, 0, 0);
    cyc(0, B, V, V, V, 0, 0);
    chk("gap s1 held", state_1, 1);
    chk("gap err1 held", err_cnt_1, 2);
    cyc(1, B, V, V, V, 0, 0);
    chk("gap s1 3rd", state_1, 1);
    cyc(1, B, V, V, V, 0, 0);
    chk("gap s1 failed", state_1, 2);
    chk("gap evt_id", evt.evt_id, 1);
    cyc(1, V, V, V, V, 1, 0);

    // saturation, then clear against mismatch and ack
    repeat (300) cyc(1, B, V, V, V, 0, 0);
    chk("sat err1", err_cnt_1, 255);
    cyc(1, B, B, B, V, 1, 1);
    chk("clr s1", state_1, 0);
    chk("clr err1", err_cnt_1, 0);
    chk("clr err2", err_cnt_2, 0);
    chk("clr valid", evt.evt_valid, 0);

    // no-majority detection
    cyc(1, 8'd5, 8'd6, 8'd7, 8'd6, 0, 0);
    chk("nomaj set", uncorr, NOMAJ);
    cyc(1, V, V, V, V, 0, 0);
    chk("nomaj sticky", uncorr, NOMAJ);
    cyc(1, V, V, V, V, 1, 0);
    chk("nomaj clear", uncorr, 0);

    // randomized traffic
    for (int i = 1; i <= 3; i++) bad[i] = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        @(negedge clk); #1; rst = 1'b1;
        @(negedge clk); #1; rst = 1'b0;
      end
      rv = 8'($urandom);
      for (int i = 1; i <= 3; i++) begin
        if ($urandom_range(0, 9) == 0) bad[i] = ~bad[i];
        if ($urandom_range(0, 99) < (bad[i] ? 90 : 5))
          rq[i] = rv ^ 8'($urandom_range(1, 255));
        else
          rq[i] = rv;
      end
      if ($urandom_range(0, 29) == 0) begin
        rq[1] = rv ^ 8'd1; rq[2] = rv ^ 8'd2; rq[3] = rv ^ 8'd3;
      end
      cyc($urandom_range(0, 9) != 0, rq[1], rq[2], rq[3], rv,
          $urandom_range(0, 249) == 0, $urandom_range(0, 3) == 0);
    end

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmr_fault_monitor.md
# tmr_fault_monitor

Fault observer on the output side of the triple-redundant counter. Samples the three replica values and the voted value every cycle. Classifies each replica's disagreement as transient or persistent, and keeps saturating per-replica mismatch counts. Reports permanently failed replicas to the system controller over a valid/ack event interface.

## Interface
Parameters:
- WIDTH, 8, width of replica and voted values
- CNT_W, 8, width of each saturating mismatch counter
- PERSIST_THRESH, 4, consecutive mismatching samples that declare a replica FAILED (legal range 2..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- sample_en  in  1  sample inputs this cycle; when low, all state holds
- q_1, q_2, q_3  in  WIDTH  replica outputs
- voted_q  in  WIDTH  voter output
- clear  in  1  synchronous clear of states, counters, pending events and uncorr flag
- state_1, state_2, state_3  out  2  replica state: 00 OK, 01 SUSPECT, 10 FAILED
- err_cnt_1, err_cnt_2, err_cnt_3  out  CNT_W  saturating count of mismatching samples
- trans_cnt  out  CNT_W  saturating count of transient episodes, summed over replicas
- evt_valid  out  1  failure event pending
- evt_id  out  2  replica index of the presented event: 1, 2 or 3
- evt_ack  in  1  consumer accepts the presented event
- uncorr  out  1  sticky no-majority flag; see Configuration

## Operation
- mismatch_i = (q_i != voted_q). It is evaluated only when sample_en = 1.
- Per replica FSM, with run counter run_i of 4 bits:
  - OK: on mismatch, go to SUSPECT with run_i = 1.
  - SUSPECT, on mismatch: run_i + 1. If that value equals PERSIST_THRESH, go to FAILED.
  - SUSPECT, on no mismatch: go to OK, clear run_i, increment trans_cnt (saturating).
  - FAILED: sticky; mismatches still increment err_cnt_i. Exits only on clear or rst.
- err_cnt_i increments on every sampled mismatch and saturates at 2^CNT_W-1, with no wrap.
- trans_cnt: if several replicas end episodes on the same edge, it adds their number, saturating.
- Event queue: a 3-bit pending mask. Bit i is set on the edge where replica i enters FAILED.
  - evt_valid = |pending.
  - evt_id = lowest-index set bit.
  - evt_valid/evt_id are stable until acked.
  - evt_ack with evt_valid clears the presented bit on the edge; evt_ack without evt_valid is ignored.
  - Several replicas failing on the same edge are presented in index order.
- clear has priority over sample_en, mismatch and evt_ack on the same edge. After clear: every state OK, every counter 0, pending 0, uncorr 0.
- Reset values: state_* = 00; err_cnt_*, trans_cnt = 0; evt_valid = 0; evt_id = 0; uncorr = 0.

## Timing
- All outputs are registered except evt_valid and evt_id, which are decoded combinationally from the pending register.
- Latency: a sample at edge N is reflected in state/counters after edge N.
- The sample that first mismatches moves the state to SUSPECT after that edge.
- The PERSIST_THRESH-th consecutive mismatching sample moves the state to FAILED and raises evt_valid after the same edge.
- Non-sampling cycles (sample_en = 0) neither break nor extend a mismatch run.
- Reset mid-run, asserted at any time, clears everything immediately. The first sample after deassertion is treated as the start of a new run.

## Configuration
- TMR_MON_NOMAJ_DETECT_EN defined:
  - uncorr is set when q_1, q_2 and q_3 are pairwise different on a sampled cycle.
  - It is sticky until clear or rst.
  - Such samples still update the FSMs normally.
- Macro undefined: uncorr is tied to 0 and no detection logic is built. The port exists in both builds.

## Structure
- Package tmr_mon_pkg holds:
  - the replica_state_e enum (OK = 2'b00, SUSPECT = 2'b01, FAILED = 2'b10);
  - a saturating-increment function;
  - the default PERSIST_THRESH constant.
- Sub-module tmr_replica_tracker holds one FSM, its run counter and its err_cnt. It is instantiated three times.
- The top level contains the pending mask, the trans_cnt adder and the no-majority check.

## Test plan
All scenarios use PERSIST_THRESH = 4 and CNT_W = 8.
- Reset behaviour: assert rst for 2 cycles -> all outputs 0, state_* = OK.
- Transient fault: q_2 differs for 2 samples, then matches -> state_2 goes 01, 01, 00; err_cnt_2 = 2; trans_cnt = 1; no event.
- Persistent fault: q_3 differs for 4 samples -> state_3 = 10 after the 4th edge; evt_valid = 1 with evt_id = 3 held until evt_ack, cleared the edge after ack.
- Simultaneous failures and sampling gaps:
  - q_1 and q_2 fail on the same edge -> evt_id 1 presented first, then 2 after ack.
  - A run interrupted by sample_en = 0 still fails on its 4th mismatching sample.
- Saturation and clear: q_1 mismatches 300 samples -> err_cnt_1 = 255.
  - clear with a simultaneous mismatch and evt_ack -> everything returns to 0/OK.
- No-majority detection: q = 5, 6, 7 sampled -> uncorr = 1 with TMR_MON_NOMAJ_DETECT_EN defined, 0 without; it remains set until clear.
